// File: rtl/rf_wb_arbiter_pkg.sv
// ============================================================================
// Module : rf_wb_arbiter_pkg
// Brief  : Processor-wide register file constants shared by the writeback path.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rf_wb_arbiter_pkg;
  localparam int DATA_W = 16;
  localparam int REG_W  = 4;
  localparam int CNT_W  = 2;
  localparam logic [REG_W-1:0] REG_ZERO = '0;
endpackage

`default_nettype wire

// File: rtl/rf_scoreboard.sv
// ============================================================================
// Module : rf_scoreboard
// Brief  : Per-register pending-write counters with issue gating, RAW busy
//          queries and a sticky underflow flag.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_scoreboard #(
  parameter int REG_W = rf_wb_arbiter_pkg::REG_W,
  parameter int CNT_W = rf_wb_arbiter_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iss_valid,
  input  logic [REG_W-1:0] iss_reg,
  output logic             iss_ready,
  input  logic             commit_valid,
  input  logic [REG_W-1:0] commit_reg,
  input  logic [REG_W-1:0] src1_reg,
  input  logic [REG_W-1:0] src2_reg,
  output logic             src1_busy,
  output logic             src2_busy,
  output logic             err
);
  import rf_wb_arbiter_pkg::*;

  localparam int               NUM_REGS = 2**REG_W;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [REG_W-1:0] ZERO_REG = REG_W'(REG_ZERO);

  logic [CNT_W-1:0] cnt_q [NUM_REGS];
  logic [CNT_W-1:0] cnt_d [NUM_REGS];
  logic             err_q;
  logic             err_d;
  logic             commit;
  logic             iss_fire;
  logic [CNT_W-1:0] src1_left;
  logic [CNT_W-1:0] src2_left;

  always_comb begin
    commit    = commit_valid & (commit_reg != ZERO_REG);
    // A same-cycle commit frees a slot, so a saturated counter can still accept
    iss_ready = (iss_reg == ZERO_REG) | (cnt_q[iss_reg] != CNT_MAX) |
                (commit & (commit_reg == iss_reg));
    iss_fire  = iss_valid & iss_ready & (iss_reg != ZERO_REG);

    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if (r == 0) begin
        cnt_d[r] = '0;
      end else begin
        if (iss_fire && (iss_reg == REG_W'(r)))
          cnt_d[r] = cnt_d[r] + 1'b1;
        if (commit && (commit_reg == REG_W'(r)) && (cnt_q[r] != '0))
          cnt_d[r] = cnt_d[r] - 1'b1;
      end
    end

    err_d = err_q | (commit & (cnt_q[commit_reg] == '0));

    // The committing write is forwarded by the register file, so it never stalls
    src1_left = cnt_q[src1_reg] - CNT_W'(commit & (commit_reg == src1_reg));
    src2_left = cnt_q[src2_reg] - CNT_W'(commit & (commit_reg == src2_reg));
    src1_busy = (src1_reg != ZERO_REG) & (src1_left != '0);
    src2_busy = (src2_reg != ZERO_REG) & (src2_left != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
      err_q <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
      err_q <= err_d;
    end
  end

  assign err = err_q;

endmodule

`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
// ============================================================================
// Module : rf_wb_arbiter
// Brief  : Round-robin arbiter for the register file write port with a
//          registered write stage and a RAW hazard scoreboard.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_wb_arbiter #(
  parameter int DATA_W = rf_wb_arbiter_pkg::DATA_W,
  parameter int REG_W  = rf_wb_arbiter_pkg::REG_W,
  parameter int CNT_W  = rf_wb_arbiter_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [REG_W-1:0]  req0_reg,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [REG_W-1:0]  req1_reg,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              iss_valid,
  output logic              iss_ready,
  input  logic [REG_W-1:0]  iss_reg,
  input  logic [REG_W-1:0]  src1_reg,
  input  logic [REG_W-1:0]  src2_reg,
  output logic              src1_busy,
  output logic              src2_busy,
  output logic              wr_en,
  output logic [REG_W-1:0]  wr_reg,
  output logic [DATA_W-1:0] wr_data,
  output logic              err
);
  import rf_wb_arbiter_pkg::*;

  localparam logic [REG_W-1:0] ZERO_REG = REG_W'(REG_ZERO);

  logic              grant0;
  logic              grant1;
  logic              rr_ptr_q;
  logic              rr_ptr_d;
  logic              wr_en_q;
  logic              wr_en_d;
  logic [REG_W-1:0]  wr_reg_q;
  logic [REG_W-1:0]  wr_reg_d;
  logic [DATA_W-1:0] wr_data_q;
  logic [DATA_W-1:0] wr_data_d;

  always_comb begin
    grant0    = req0_valid & (~req1_valid | ~rr_ptr_q);
    grant1    = req1_valid & (~req0_valid |  rr_ptr_q);
    rr_ptr_d  = rr_ptr_q;
    wr_en_d   = 1'b0;
    wr_reg_d  = wr_reg_q;
    wr_data_d = wr_data_q;
    // R0 writes are absorbed: accepted, but never reach the register file
    if (grant0) begin
      rr_ptr_d  = 1'b1;
      wr_en_d   = (req0_reg != ZERO_REG);
      wr_reg_d  = req0_reg;
      wr_data_d = req0_data;
    end else if (grant1) begin
      rr_ptr_d  = 1'b0;
      wr_en_d   = (req1_reg != ZERO_REG);
      wr_reg_d  = req1_reg;
      wr_data_d = req1_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_reg_q  <= '0;
      wr_data_q <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      wr_en_q   <= wr_en_d;
      wr_reg_q  <= wr_reg_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign wr_en      = wr_en_q;
  assign wr_reg     = wr_reg_q;
  assign wr_data    = wr_data_q;

  rf_scoreboard #(
    .REG_W (REG_W),
    .CNT_W (CNT_W)
  ) u_scoreboard (
    .clk          (clk),
    .rst          (rst),
    .iss_valid    (iss_valid),
    .iss_reg      (iss_reg),
    .iss_ready    (iss_ready),
    .commit_valid (wr_en_q),
    .commit_reg   (wr_reg_q),
    .src1_reg     (src1_reg),
    .src2_reg     (src2_reg),
    .src1_busy    (src1_busy),
    .src2_busy    (src2_busy),
    .err          (err)
  );

endmodule

`default_nettype wire
